// File: rtl/alu_cdb_if.sv
// Bus bundle between the issue side (reservation stations) and the ALU/CDB cluster.
// The master drives the per-lane operations; the slave returns the combinational
// ALU results and the registered per-tag broadcast.
interface alu_cdb_if #(
    parameter int NUM_ALU   = 4,
    parameter int ROB_DEPTH = 8
);
    localparam int TAG_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

    logic [NUM_ALU-1:0]              exec;
    logic [NUM_ALU-1:0][TAG_W-1:0]   tag;
    logic [NUM_ALU-1:0]              op_imm;
    logic [NUM_ALU-1:0][2:0]         funct3;
    logic [NUM_ALU-1:0]              funct7;
    logic [NUM_ALU-1:0][31:0]        src1;
    logic [NUM_ALU-1:0][31:0]        src2;
    logic [NUM_ALU-1:0][31:0]        alu_result;
    logic [ROB_DEPTH-1:0][31:0]      cdb_data;
    logic [ROB_DEPTH-1:0]            cdb_valid;
    logic                            collision;

    modport master (
        output exec, tag, op_imm, funct3, funct7, src1, src2,
        input  alu_result, cdb_data, cdb_valid, collision
    );

    modport slave (
        input  exec, tag, op_imm, funct3, funct7, src1, src2,
        output alu_result, cdb_data, cdb_valid, collision
    );
endinterface

// File: rtl/alu_cdb_cluster.sv
// NUM_ALU combinational RV32I ALU lanes feeding a per-tag common data bus.
// Each ROB tag has its own registered data/valid slot; when several executing
// lanes target the same tag in one cycle, the lowest-index lane wins and the
// collision flag is raised for one cycle.
module alu_cdb_cluster #(
    parameter int NUM_ALU   = 4,
    parameter int ROB_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_cdb_if.slave bus
);
    localparam int TAG_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

    logic [ROB_DEPTH-1:0]        hit;
    logic [ROB_DEPTH-1:0][31:0]  win_data;
    logic                        coll_next;

    function automatic logic [31:0] alu_calc(
        input logic        imm,
        input logic [2:0]  f3,
        input logic        f7,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        r  = '0;
        case (f3)
            // OP-IMM has no subi, so funct7 only selects sub in register form
            3'b000:  r = (f7 && !imm) ? (a - b) : (a + b);
            3'b001:  r = a << sh;
            3'b010:  r = {31'b0, ($signed(a) < $signed(b))};
            3'b011:  r = {31'b0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = f7 ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-lane ALU, evaluated every cycle independent of exec
    always_comb begin
        for (int i = 0; i < NUM_ALU; i++) begin
            bus.alu_result[i] = alu_calc(bus.op_imm[i], bus.funct3[i], bus.funct7[i],
                                         bus.src1[i], bus.src2[i]);
        end
    end

    // Tag arbitration: scan lanes low to high so the first claimant owns the slot
    always_comb begin
        hit       = '0;
        win_data  = '0;
        coll_next = 1'b0;
        for (int i = 0; i < NUM_ALU; i++) begin
            if (bus.exec[i] && (int'(bus.tag[i]) < ROB_DEPTH)) begin
                if (hit[bus.tag[i]]) begin
                    coll_next = 1'b1;
                end else begin
                    hit[bus.tag[i]]      = 1'b1;
                    win_data[bus.tag[i]] = bus.alu_result[i];
                end
            end
        end
    end

    // Broadcast registers: strobe is one cycle per exec, data holds between strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.cdb_valid <= '0;
            bus.cdb_data  <= '0;
            bus.collision <= 1'b0;
        end else begin
            bus.cdb_valid <= hit;
            bus.collision <= coll_next;
            for (int t = 0; t < ROB_DEPTH; t++) begin
                if (hit[t]) begin
                    bus.cdb_data[t] <= win_data[t];
                end
            end
        end
    end

    logic unused_tag_w;
    assign unused_tag_w = (TAG_W == 0);
endmodule

// File: tb/tb_alu_cdb_cluster.sv
// Self-checking bench for alu_cdb_cluster: directed ALU vector table, hand
// sequences for the broadcast corner cases, then randomized traffic against a
// behavioural reference model.
module tb_alu_cdb_cluster;
    localparam int NA = 4;
    localparam int RD = 8;

    logic clk;
    logic reset_n;

    alu_cdb_if #(.NUM_ALU(NA), .ROB_DEPTH(RD)) bus ();

    alu_cdb_cluster #(.NUM_ALU(NA), .ROB_DEPTH(RD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_data  [RD];
    logic        exp_valid [RD];
    logic        exp_coll;

    typedef struct {
        logic        imm;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [12];

    // Reference ALU written from the instruction semantics, not the RTL structure
    function automatic logic [31:0] ref_alu(input logic imm, input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: return (f7 && !imm) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (f7 && a[31]) return ~((~a) >> sh);
                return a >> sh;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < RD; t++) begin
            exp_data[t]  = '0;
            exp_valid[t] = 1'b0;
        end
        exp_coll = 1'b0;
    endtask

    // Next-state of the broadcast table: count claimants per tag, then let the
    // lowest lane write last-wins by walking lanes from the top down
    task automatic model_step();
        int cnt [RD];
        for (int t = 0; t < RD; t++) begin
            cnt[t]       = 0;
            exp_valid[t] = 1'b0;
        end
        for (int i = NA - 1; i >= 0; i--) begin
            if (bus.exec[i]) begin
                cnt[int'(bus.tag[i])]++;
                exp_valid[int'(bus.tag[i])] = 1'b1;
                exp_data[int'(bus.tag[i])]  = ref_alu(bus.op_imm[i], bus.funct3[i], bus.funct7[i],
                                                      bus.src1[i], bus.src2[i]);
            end
        end
        exp_coll = 1'b0;
        for (int t = 0; t < RD; t++) if (cnt[t] > 1) exp_coll = 1'b1;
    endtask

    task automatic check_cdb();
        for (int t = 0; t < RD; t++) begin
            check32($sformatf("cdb_valid[%0d]", t), 32'(bus.cdb_valid[t]), 32'(exp_valid[t]));
            check32($sformatf("cdb_data[%0d]", t), bus.cdb_data[t], exp_data[t]);
        end
        check32("collision", 32'(bus.collision), 32'(exp_coll));
    endtask

    task automatic set_lane(input int i, input logic e, input logic [2:0] tg, input logic imm,
                            input logic [2:0] f3, input logic f7, input logic [31:0] a,
                            input logic [31:0] b);
        bus.exec[i]   = e;
        bus.tag[i]    = tg;
        bus.op_imm[i] = imm;
        bus.funct3[i] = f3;
        bus.funct7[i] = f7;
        bus.src1[i]   = a;
        bus.src2[i]   = b;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NA; i++) set_lane(i, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
    endtask

    // One clock: check combinational results, advance model, check registered outputs
    task automatic cycle();
        #1;
        for (int i = 0; i < NA; i++) begin
            check32($sformatf("alu_result[%0d]", i), bus.alu_result[i],
                    ref_alu(bus.op_imm[i], bus.funct3[i], bus.funct7[i], bus.src1[i], bus.src2[i]));
        end
        model_step();
        @(posedge clk);
        #1;
        check_cdb();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 1'b1, 32'd3,          32'd5,  32'hFFFF_FFFE};
        vecs[1]  = '{1'b0, 3'b101, 1'b1, 32'h8000_0000, 32'd4,  32'hF800_0000};
        vecs[2]  = '{1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd1};
        vecs[3]  = '{1'b0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0};
        vecs[4]  = '{1'b1, 3'b000, 1'b1, 32'd0,          32'd11, 32'd11};
        vecs[5]  = '{1'b0, 3'b111, 1'b0, 32'h1234,      32'd0,  32'd0};
        vecs[6]  = '{1'b0, 3'b001, 1'b0, 32'h1,         32'd35, 32'h8};
        vecs[7]  = '{1'b0, 3'b100, 1'b0, 32'hF0F0,      32'hFF, 32'hF00F};
        vecs[8]  = '{1'b0, 3'b101, 1'b0, 32'h8000_0000, 32'd4,  32'h0800_0000};
        vecs[9]  = '{1'b0, 3'b110, 1'b0, 32'h0F00,      32'h00F0, 32'h0FF0};
        vecs[10] = '{1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0};
        vecs[11] = '{1'b1, 3'b101, 1'b1, 32'hF000_0000, 32'd31, 32'hFFFF_FFFF};

        reset_n = 1'b1;
        clear_lanes();
        model_reset();
        #3 reset_n = 1'b0;
        #1;
        check32("reset cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check32("reset collision", 32'(bus.collision), 32'd0);
        for (int t = 0; t < RD; t++) check32($sformatf("reset cdb_data[%0d]", t), bus.cdb_data[t], 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed ALU table on lane 0 (exec low: result must not depend on it)
        for (int k = 0; k < 12; k++) begin
            set_lane(0, 1'b0, 3'd0, vecs[k].imm, vecs[k].f3, vecs[k].f7, vecs[k].a, vecs[k].b);
            #1;
            check32($sformatf("vec%0d alu_result", k), bus.alu_result[0], vecs[k].res);
        end
        clear_lanes();

        // Single and after-reset broadcast: AND with zero on tag 1
        set_lane(0, 1'b1, 3'd1, 1'b0, 3'b111, 1'b0, 32'h1234, 32'd0);
        cycle();
        check32("and tag1 valid vector", 32'(bus.cdb_valid), 32'h02);
        check32("and tag1 data", bus.cdb_data[1], 32'd0);

        // OP-IMM add ignores funct7, then idle cycle holds data
        clear_lanes();
        set_lane(1, 1'b1, 3'd2, 1'b1, 3'b000, 1'b1, 32'd0, 32'd11);
        cycle();
        check32("addi tag2 data", bus.cdb_data[2], 32'd11);
        clear_lanes();
        cycle();
        check32("idle tag2 valid", 32'(bus.cdb_valid[2]), 32'd0);
        check32("idle tag2 hold", bus.cdb_data[2], 32'd11);

        // All lanes on distinct tags
        set_lane(0, 1'b1, 3'd0, 1'b0, 3'b000, 1'b0, 32'd10, 32'd1);
        set_lane(1, 1'b1, 3'd3, 1'b0, 3'b000, 1'b0, 32'd20, 32'd2);
        set_lane(2, 1'b1, 3'd5, 1'b0, 3'b000, 1'b0, 32'd30, 32'd3);
        set_lane(3, 1'b1, 3'd7, 1'b0, 3'b000, 1'b0, 32'd40, 32'd4);
        cycle();
        check32("four lanes valid vector", 32'(bus.cdb_valid), 32'hA9);
        check32("four lanes tag7 data", bus.cdb_data[7], 32'd44);
        check32("four lanes collision", 32'(bus.collision), 32'd0);

        // Lanes 0 and 2 collide on tag 4
        clear_lanes();
        set_lane(0, 1'b1, 3'd4, 1'b0, 3'b000, 1'b0, 32'd3, 32'd4);
        set_lane(2, 1'b1, 3'd4, 1'b0, 3'b000, 1'b0, 32'd4, 32'd5);
        cycle();
        check32("collide tag4 data", bus.cdb_data[4], 32'd7);
        check32("collide flag", 32'(bus.collision), 32'd1);
        clear_lanes();
        cycle();
        check32("collide flag cleared", 32'(bus.collision), 32'd0);

        // Back-to-back on tag 6 with changing data
        set_lane(3, 1'b1, 3'd6, 1'b0, 3'b110, 1'b0, 32'hA0, 32'h05);
        cycle();
        check32("b2b first data", bus.cdb_data[6], 32'hA5);
        set_lane(3, 1'b1, 3'd6, 1'b0, 3'b100, 1'b0, 32'hFF, 32'h0F);
        cycle();
        check32("b2b second valid", 32'(bus.cdb_valid[6]), 32'd1);
        check32("b2b second data", bus.cdb_data[6], 32'hF0);

        // Asynchronous reset while tag 1 is strobing
        clear_lanes();
        set_lane(0, 1'b1, 3'd1, 1'b0, 3'b000, 1'b0, 32'd100, 32'd1);
        cycle();
        check32("pre-reset valid1", 32'(bus.cdb_valid[1]), 32'd1);
        clear_lanes();
        #2 reset_n = 1'b0;
        #1;
        check32("async reset cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check32("async reset data1", bus.cdb_data[1], 32'd0);
        check32("async reset data6", bus.cdb_data[6], 32'd0);
        check32("async reset collision", 32'(bus.collision), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic; narrow tag range half the time to provoke collisions
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NA; i++) begin
                set_lane(i, 1'($urandom_range(0, 1)),
                         (n % 2 == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)),
                         1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_cdb_cluster.md
ALU_CDB_CLUSTER -- requirements
Module: alu_cdb_cluster

Interface
REQ-001 Parameter NUM_ALU, default 4: number of ALU lanes.
REQ-002 Parameter ROB_DEPTH, default 8: number of CDB entries (ROB tags); tag width is log2(ROB_DEPTH), 3 bits at default.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 exec[NUM_ALU]  in  1 each  lane i holds a valid operation this cycle (reservation-station start_exe).
REQ-006 tag[NUM_ALU]  in  3 each  destination ROB tag of lane i.
REQ-007 op_imm[NUM_ALU]  in  1 each  1 = OP-IMM form, 0 = register-register form.
REQ-008 funct3[NUM_ALU]  in  3 each  RV32I funct3.
REQ-009 funct7[NUM_ALU]  in  1 each  funct7 bit 5 (sub/sra select).
REQ-010 src1[NUM_ALU], src2[NUM_ALU]  in  32 each  operands; src2 already holds the sign-extended immediate when op_imm=1.
REQ-011 alu_result[NUM_ALU]  out  32 each  combinational result of lane i.
REQ-012 cdb_data[ROB_DEPTH]  out  32 each  registered broadcast data per tag.
REQ-013 cdb_valid[ROB_DEPTH]  out  1 each  registered broadcast strobe per tag.
REQ-014 collision  out  1  registered flag: two or more executing lanes shared a tag in the previous cycle.

Function
REQ-015 The ALU SHALL be purely combinational, computing alu_result from the current inputs regardless of exec.
REQ-016 funct3 decode: 000 add, or sub when funct7=1 and op_imm=0; 001 sll; 010 slt (signed, result 1/0); 011 sltu; 100 xor; 101 srl, or sra when funct7=1; 110 or; 111 and.
REQ-017 Shift amount = src2[4:0]; sra replicates src1[31]; add/sub wrap modulo 2^32 with no overflow flag.
REQ-018 With op_imm=1 and funct3=000, funct7 SHALL be ignored and the operation is always add.
REQ-019 On each rising edge, for every tag t: if some lane has exec=1 and tag=t, then cdb_valid[t]<=1 and cdb_data[t]<=that lane's alu_result; otherwise cdb_valid[t]<=0 and cdb_data[t] holds its value.
REQ-020 Latency: exactly one cycle from exec sampled high to cdb_valid high; a valid strobe lasts one cycle per exec cycle.
REQ-021 Tag conflict: the lowest-index executing lane wins the entry, the other lanes' results are dropped, and collision<=1 on that edge; otherwise collision<=0.
REQ-022 Different tags SHALL broadcast in the same cycle independently; all NUM_ALU lanes may complete simultaneously.
REQ-023 Back-to-back exec on the same tag SHALL produce consecutive valid cycles, each carrying the data of its own cycle.
REQ-024 The cluster SHALL have no backpressure and no ready output; an exec is always accepted.

Reset
REQ-025 While reset_n=0: cdb_valid all 0, cdb_data all 32'h0, collision 0, applied immediately without waiting for clk.
REQ-026 On reset deassertion, the first edge with any exec high SHALL produce a broadcast as in REQ-019; reset asserted mid-broadcast clears valid at once.

Verification
REQ-027 Lane0: exec=1, tag=1, op_imm=0, funct3=111, src1=0x1234, src2=0 -> next cycle cdb_valid[1]=1, cdb_data[1]=0, other valids 0.
REQ-028 Lane1: tag=2, op_imm=1, funct3=000, funct7=1, src1=0, src2=11 -> cdb_data[2]=11 (add, not sub); the following cycle, with exec low, cdb_valid[2]=0 and cdb_data[2] holds 11.
REQ-029 Lane0: funct3=000, funct7=1, op_imm=0, src1=3, src2=5 -> 0xFFFFFFFE; funct3=101, funct7=1, src1=0x80000000, src2=4 -> 0xF8000000; funct3=010, src1=0xFFFFFFFF, src2=1 -> 1; funct3=011, same operands -> 0.
REQ-030 All four lanes execute with tags 0,3,5,7 -> all four entries valid on the same next cycle with correct data, collision=0.
REQ-031 Lanes 0 and 2 both execute with tag=4 (results 7 and 9) -> cdb_data[4]=7, collision=1 for one cycle.
REQ-032 Drop reset_n low asynchronously while cdb_valid[1]=1 -> all outputs cleared before the next clk edge.
